// File: rtl/pipelined_carry_adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
// Slice width helper, configuration sanity check and the per-stage record
// layout. The record is a macro so each stage can instantiate it at its own
// slice width.
// Optional build macro used by this slice: PIPELINED_CARRY_ADDER_SUB_EN.

`ifndef PCA_STAGE_REC
`define PCA_STAGE_REC(W) struct packed { logic valid; logic carry; logic [(W)-1:0] psum; }
`endif

package pipelined_carry_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Bits rippled by one stage; guards the divide so a bad STAGES value
  // reaches the configuration check instead of failing on a divide by zero.
  function automatic int slice_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  // The operand must split into equal, non-empty slices.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Stage record at the default geometry, kept for code that wants a
  // fixed-width view of one pipeline slot.
  typedef `PCA_STAGE_REC(DEFAULT_WIDTH / DEFAULT_STAGES) stage_rec_t;

endpackage

// File: rtl/pipelined_carry_adder_if.sv
// Operand/result bus of the pipelined carry adder with valid/ready on both
// sides. The master drives operands and consumes results; the adder is the
// slave. in_sub exists only when PIPELINED_CARRY_ADDER_SUB_EN is defined.

interface pipelined_carry_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/pipelined_carry_adder_fa_cell.sv
// One-bit full adder (fa_cell): the ripple element chained inside every
// pipeline stage.

module pipelined_carry_adder_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half;

  // Sum and carry of a single bit position
  always_comb begin
    half = a ^ b;
    s    = half ^ ci;
    co   = (a & b) | (ci & half);
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder.
// A WIDTH-bit add is cut into STAGES slices of SLICE bits. Stage k ripples
// slice k using the carry registered by stage k-1, so the critical path is
// one SLICE-bit ripple chain. Upper operand slices are skewed (slice k waits
// k cycles) so they meet their incoming carry; lower sum slices are deskewed
// (slice k waits STAGES-1-k cycles) so the whole sum lands in one cycle.
// A single advance signal moves or freezes the entire pipe.
// Build option: PIPELINED_CARRY_ADDER_SUB_EN adds in_sub (A - B = A + ~B + 1).

module pipelined_carry_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_carry_adder_if.slave bus
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic              advance;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] carry_vec;
  logic [WIDTH-1:0]  sum_vec;
  logic              ovf_q;

  // The pipe moves whenever the output slot is empty or being drained;
  // otherwise every register, including the outputs, holds.
  assign advance = !valid_vec[STAGES-1] || bus.out_ready;

`ifdef PIPELINED_CARRY_ADDER_SUB_EN
  // Subtract folds into the adder: invert B and force the carry-in to one.
  assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign cin_eff = bus.in_sub ? 1'b1 : bus.in_cin;
`else
  assign b_eff   = bus.in_b;
  assign cin_eff = bus.in_cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    typedef `PCA_STAGE_REC(SLICE) stage_t;

    stage_t            stage_r;
    logic [SLICE-1:0]  a_op;
    logic [SLICE-1:0]  b_op;
    logic [SLICE-1:0]  s_c;
    logic [SLICE:0]    c_c;
    logic              carry_in;
    logic              valid_in;

    if (k == 0) begin : g_head
      assign a_op     = bus.in_a[0 +: SLICE];
      assign b_op     = b_eff[0 +: SLICE];
      assign carry_in = cin_eff;
      assign valid_in = bus.in_valid;
    end else begin : g_skew
      logic [SLICE-1:0] a_sk [0:k-1];
      logic [SLICE-1:0] b_sk [0:k-1];

      // Delay this slice's operands by k cycles so they reach the ripple
      // chain together with the carry coming out of stage k-1.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            a_sk[i] <= '0;
            b_sk[i] <= '0;
          end
        end else if (advance) begin
          a_sk[0] <= bus.in_a[k*SLICE +: SLICE];
          b_sk[0] <= b_eff[k*SLICE +: SLICE];
          for (int i = 1; i < k; i++) begin
            a_sk[i] <= a_sk[i-1];
            b_sk[i] <= b_sk[i-1];
          end
        end
      end

      assign a_op     = a_sk[k-1];
      assign b_op     = b_sk[k-1];
      assign carry_in = carry_vec[k-1];
      assign valid_in = valid_vec[k-1];
    end

    assign c_c[0] = carry_in;

    for (genvar j = 0; j < SLICE; j++) begin : g_bit
      pipelined_carry_adder_fa_cell u_fa_cell (
        .a  (a_op[j]),
        .b  (b_op[j]),
        .ci (c_c[j]),
        .s  (s_c[j]),
        .co (c_c[j+1])
      );
    end

    // Stage register: the slot's valid bit (bubbles travel too), the carry
    // handed to the next slice and this slice's partial sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_r <= '0;
      end else if (advance) begin
        stage_r.valid <= valid_in;
        stage_r.carry <= c_c[SLICE];
        stage_r.psum  <= s_c;
      end
    end

    assign valid_vec[k] = stage_r.valid;
    assign carry_vec[k] = stage_r.carry;

    if (k == STAGES - 1) begin : g_tail
      assign sum_vec[k*SLICE +: SLICE] = stage_r.psum;

      // Signed overflow comes from the carries around the MSB and is
      // registered alongside the last slice so it lines up with out_sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= c_c[SLICE-1] ^ c_c[SLICE];
        end
      end
    end else begin : g_deskew
      logic [SLICE-1:0] ds [0:STAGES-2-k];

      // Hold the finished low slice until the upper slices catch up.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i <= STAGES-2-k; i++) begin
            ds[i] <= '0;
          end
        end else if (advance) begin
          ds[0] <= stage_r.psum;
          for (int i = 1; i <= STAGES-2-k; i++) begin
            ds[i] <= ds[i-1];
          end
        end
      end

      assign sum_vec[k*SLICE +: SLICE] = ds[STAGES-2-k];
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_vec[STAGES-1];
  assign bus.out_sum   = sum_vec;
  assign bus.out_cout  = carry_vec[STAGES-1];
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench for pipelined_carry_adder at WIDTH=8, STAGES=2.
// A queue-based arithmetic model predicts every result; one monitor at the
// falling edge compares the output bus with it. Directed sequences pin
// known sums, latency, stalls and reset flushing; a random phase mixes
// bubbles and back-pressure. Honours PIPELINED_CARRY_ADDER_SUB_EN.

module tb_pipelined_carry_adder;

  localparam int W = 8;
  localparam int S = 2;

  logic clk;
  logic rst;

  int checks;
  int passes;

  logic [9:0] exp_q [$];
  logic       sub_now;

  pipelined_carry_adder_if #(.WIDTH(W)) bus ();

  pipelined_carry_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Abort if the run ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected {ovf, cout, sum} straight from the arithmetic definition
  function automatic logic [9:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cc;
    bb   = s ? ~b : b;
    cc   = s ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    return {(a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]), full[W], full[W-1:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then let an edge pass
  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic s, input logic ordy);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = c;
    bus.out_ready = ordy;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    bus.in_sub    = s;
`else
    sub_now       = s;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // One operation into an empty pipe: latency and literal result
  task automatic runDirected(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic s, input logic [W-1:0] esum,
                             input logic ecout, input logic eovf);
    int n;
    applyStimulus(1'b1, a, b, c, s, 1'b1);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'(S));
    checkOutput({name, "_sum"}, 32'(bus.out_sum), 32'(esum));
    checkOutput({name, "_cout"}, 32'(bus.out_cout), 32'(ecout));
    checkOutput({name, "_ovf"}, 32'(bus.out_ovf), 32'(eovf));
  endtask

  // Compare process: every cycle the output is valid it must match the
  // oldest outstanding prediction; accepted inputs enqueue new predictions.
  always @(negedge clk) begin
    logic s_in;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    s_in = bus.in_sub;
`else
    s_in = 1'b0;
`endif
    if (rst) begin
      exp_q.delete();
    end else begin
      checkOutput("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", 32'(1), 32'(0));
        end else begin
          checkOutput("mon_sum", 32'(bus.out_sum), 32'(exp_q[0][W-1:0]));
          checkOutput("mon_cout", 32'(bus.out_cout), 32'(exp_q[0][W]));
          checkOutput("mon_ovf", 32'(bus.out_ovf), 32'(exp_q[0][W+1]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, s_in));
      end
    end
  end

  initial begin
    int vcount;
    int tries;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    checks  = 0;
    passes  = 0;
    sub_now = 1'b0;
    rst     = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("rst_out_sum", 32'(bus.out_sum), 32'(0));
    checkOutput("rst_out_cout", 32'(bus.out_cout), 32'(0));
    checkOutput("rst_out_ovf", 32'(bus.out_ovf), 32'(0));
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'(1));

    $display("[TB] directed sums");
    runDirected("t1_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    runDirected("t2_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    runDirected("t2_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    runDirected("cin_ff_00", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    runDirected("neg_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    runDirected("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    runDirected("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif
    idle(3);

    $display("[TB] back-to-back burst");
    vcount = 0;
    for (int i = 0; i < 8 + S; i++) begin
      if (i < 8) applyStimulus(1'b1, 8'(i * 37 + 5), 8'(i * 11 + 200), 1'(i), 1'b0, 1'b1);
      else       applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (bus.out_valid) vcount++;
    end
    checkOutput("burst_count", 32'(vcount), 32'(8));
    idle(3);

    $display("[TB] back-pressure stall");
    applyStimulus(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_in_ready", 32'(bus.in_ready), 32'(0));
      checkOutput("stall_out_valid", 32'(bus.out_valid), 32'(1));
      checkOutput("stall_sum_hold", 32'(bus.out_sum), 32'(8'h33));
    end
    idle(4);
    checkOutput("stall_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] reset with results in flight");
    applyStimulus(1'b1, 8'hA0, 8'h0B, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hC0, 8'h0D, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("flush_out_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("flush_out_sum", 32'(bus.out_sum), 32'(0));
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (bus.out_valid) vcount++;
    end
    checkOutput("flush_no_ghost", 32'(vcount), 32'(0));
    runDirected("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 8'hFF;
        1:       ra = 8'h7F;
        2:       ra = 8'h80;
        default: ra = 8'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 8'h01 : 8'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom),
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
                    1'($urandom),
`else
                    1'b0,
`endif
                    $urandom_range(0, 9) < 7);
    end

    tries = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && tries < 30) begin
      idle(1);
      tries++;
    end
    checkOutput("final_drain", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
